hash_requester: RTL and testbench

//  Initiator side of the start/data/finished/hash handshake served by the hash

---
 rtl/hash_if_pkg.sv | 20 ++
 rtl/hash_req_buf.sv | 29 ++
 rtl/hash_requester.sv | 156 +++++++++++++++
 tb/tb_hash_requester.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_if_pkg.sv
// Shared encodings for the start/data/finished/hash handshake between the
// requester and the hash core.
package hash_if_pkg;

  localparam logic [1:0] START_IDLE = 2'b00;
  localparam logic [1:0] START_GO   = 2'b01;
  localparam logic [2:0] FIN_ACK    = 3'b001;
  localparam logic [2:0] FIN_DONE   = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    STREAM,
    WAIT_DONE,
    RESULT,
    ERR
  } state_t;

endpackage

// File: rtl/hash_req_buf.sv
// Message block buffer: WORDS x 32 register file with one write port and one
// asynchronous read port. Contents are not reset.
module hash_req_buf #(
  parameter int WORDS = 4,
  parameter int IW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] mem_d [WORDS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/hash_requester.sv
// Initiator for the hash core: buffers one block, runs start/ack, streams words,
// waits for done and offers the digest downstream. Optional timeout: HASH_REQ_TIMEOUT_EN.
module hash_requester
  import hash_if_pkg::*;
#(
  parameter int WORDS          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  output logic [1:0]  start,
  output logic [31:0] data,
  input  logic [2:0]  finished,
  input  logic [31:0] hash,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_hash,
  output logic        busy,
  output logic        err,
  output state_t      dbg_state
);

  localparam int          IW   = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  // Valid/ready: a beat transfers on a rising edge where valid && ready are
  // both high; the source holds valid and payload stable until that edge.

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   res_hash_q, res_hash_d;
  logic          res_valid_q, res_valid_d;
  logic          buf_we;
  logic [31:0]   rd_data;
  logic          tmo;

  hash_req_buf #(.WORDS(WORDS), .IW(IW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (req_data),
    .raddr (idx_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    res_hash_d  = res_hash_q;
    res_valid_d = res_valid_q;
    buf_we      = 1'b0;
    case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (req_valid) begin
          buf_we = 1'b1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      START: begin
        // buf[0] is already on data during the ack cycle, so streaming resumes at 1
        if (finished == FIN_ACK) begin
          idx_d   = IW'(1);
          state_d = STREAM;
        end else if (tmo) begin
          state_d = ERR;
        end
      end
      STREAM: begin
        if (idx_q == LAST) state_d = WAIT_DONE;
        else               idx_d   = idx_q + 1'b1;
      end
      WAIT_DONE: begin
        if (finished == FIN_DONE) begin
          res_hash_d  = hash;
          res_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = RESULT;
        end else if (tmo) begin
          idx_d   = '0;
          state_d = ERR;
        end
      end
      RESULT: begin
        if (result_ready) begin
          res_valid_d = 1'b0;
          state_d     = FILL;
        end
      end
      ERR: begin
        idx_d   = '0;
        state_d = FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      res_hash_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      res_hash_q  <= res_hash_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef HASH_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting = (state_q == START) || (state_q == WAIT_DONE);
  assign tmo     = waiting && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Any state change (including START -> STREAM) restarts the count at zero
  always_comb begin
    cnt_d = '0;
    if (waiting && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err = (state_q == ERR);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo            = 1'b0;
  assign err            = 1'b0;
`endif

  assign req_ready    = (state_q == FILL);
  assign start        = (state_q == START) ? START_GO : START_IDLE;
  assign data         = ((state_q == START) || (state_q == STREAM) || (state_q == WAIT_DONE))
                        ? rd_data : '0;
  assign result_valid = res_valid_q;
  assign result_hash  = res_hash_q;
  assign busy         = (state_q != IDLE) && (state_q != FILL);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hash_requester.sv
// Bench for hash_requester: randomized blocks with a behavioural core model and
// scoreboards for core-visible words and returned digests.
module tb_hash_requester;
  import hash_if_pkg::*;

  localparam int WORDS = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic [1:0]  start;
  logic [31:0] data;
  logic [2:0]  finished = '0;
  logic [31:0] hash = '0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result_hash;
  logic        busy;
  logic        err;
  state_t      dbg_state;

  hash_requester #(.WORDS(WORDS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .start        (start),
    .data         (data),
    .finished     (finished),
    .hash         (hash),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_hash  (result_hash),
    .busy         (busy),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_hash_q[$];
  int          stream_left = 0;
  logic [31:0] last_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] junk(input bit allow_ack, input bit allow_done);
    logic [2:0] c;
    do c = 3'($urandom_range(7));
    while ((c == FIN_ACK && !allow_ack) || (c == FIN_DONE && !allow_done));
    return c;
  endfunction

  // core model + scoreboard: the core sees WORDS words starting at the ack cycle
  always @(negedge clk) begin
    if (!reset) begin
      stream_left = 0;
    end else begin
      if (start == START_GO && finished == FIN_ACK) begin
        if (exp_q.size() == 0) check("stream_extra", data, 32'hxxxxxxxx);
        else check("stream_word", data, exp_q.pop_front());
        stream_left = WORDS - 1;
      end else if (stream_left > 0) begin
        check("stream_start_idle", 32'(start), 32'(START_IDLE));
        if (exp_q.size() == 0) check("stream_extra", data, 32'hxxxxxxxx);
        else check("stream_word", data, exp_q.pop_front());
        stream_left--;
      end
      if (result_valid && result_ready) begin
        if (exp_hash_q.size() == 0) check("result_extra", result_hash, 32'hxxxxxxxx);
        else check("result_hash_pop", result_hash, exp_hash_q.pop_front());
      end
    end
  end

  // driver: mode 0 = always valid, 1 = valid every other cycle, 2 = random gaps
  task automatic send_block(input int mode, input logic [31:0] words[WORDS]);
    int got = 0;
    int cyc = 0;
    while (got < WORDS) begin
      case (mode)
        0:       req_valid = 1'b1;
        1:       req_valid = (cyc % 2 == 0);
        default: req_valid = ($urandom_range(99) >= 30);
      endcase
      req_data = req_valid ? words[got] : $urandom();
      @(negedge clk);
      if (req_valid && req_ready) begin
        exp_q.push_back(words[got]);
        got++;
      end
      tick();
      if (got < WORDS) check("no_early_start", 32'(start), 32'(START_IDLE));
      cyc++;
      if (cyc > 200) begin
        check("fill_timeout", 32'(got), 32'(WORDS));
        break;
      end
    end
    req_valid = 1'b0;
    last_word = words[WORDS-1];
    check("start_latency", 32'(start), 32'(START_GO));
    check("req_ready_start", 32'(req_ready), 32'd0);
  endtask

  task automatic ack_phase(input int delay, input bit inject_done);
    for (int i = 0; i < delay; i++) begin
      finished = (inject_done && i == 0) ? FIN_DONE : junk(1'b0, 1'b1);
      hash = $urandom();
      tick();
      check("start_held", 32'(start), 32'(START_GO));
      check("req_ready_start", 32'(req_ready), 32'd0);
      check("busy_start", 32'(busy), 32'd1);
      check("err_start", 32'(err), 32'd0);
    end
    finished = FIN_ACK;
    tick();
    finished = 3'b000;
    check("start_drop", 32'(start), 32'(START_IDLE));
    for (int i = 0; i < WORDS - 1; i++) begin
      tick();
      check("result_idle_stream", 32'(result_valid), 32'd0);
    end
  endtask

  task automatic done_phase(input int wait_cyc, input int hold_cyc, input logic [31:0] h);
    for (int i = 0; i < wait_cyc; i++) begin
      finished = junk(1'b1, 1'b0);
      hash = $urandom();
      tick();
      check("wait_data_hold", data, last_word);
      check("wait_no_result", 32'(result_valid), 32'd0);
      check("req_ready_wait", 32'(req_ready), 32'd0);
    end
    finished = FIN_DONE;
    hash = h;
    exp_hash_q.push_back(h);
    tick();
    finished = 3'b000;
    hash = $urandom();
    check("result_valid_latency", 32'(result_valid), 32'd1);
    check("result_hash", result_hash, h);
    check("busy_result", 32'(busy), 32'd1);
    for (int i = 0; i < hold_cyc; i++) begin
      tick();
      check("result_valid_hold", 32'(result_valid), 32'd1);
      check("result_hash_stable", result_hash, h);
      check("req_ready_result", 32'(req_ready), 32'd0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("result_valid_clear", 32'(result_valid), 32'd0);
    check("fill_after_result", 32'(req_ready), 32'd1);
    check("busy_fill", 32'(busy), 32'd0);
  endtask

  task automatic rand_words(output logic [31:0] w[WORDS]);
    for (int i = 0; i < WORDS; i++) w[i] = $urandom();
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] blk[WORDS];

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(start), 32'(START_IDLE));
    check("rst_data", data, 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // fixed block, ack three cycles after start, fixed digest held 5 cycles
    blk = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_block(0, blk);
    ack_phase(3, 1'b0);
    done_phase(2, 5, 32'h01234567);

    // every-other-cycle valid, done injected while waiting for ack
    rand_words(blk);
    send_block(1, blk);
    ack_phase(3, 1'b1);
    done_phase(1, 0, $urandom());

    // reset mid-stream discards the block
    rand_words(blk);
    send_block(0, blk);
    finished = FIN_ACK;
    tick();
    finished = 3'b000;
    tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_start", 32'(start), 32'(START_IDLE));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rand_words(blk);
    send_block(2, blk);
    ack_phase(1, 1'b0);
    done_phase(0, 1, $urandom());

    // randomized blocks
    for (int b = 0; b < 12; b++) begin
      rand_words(blk);
      send_block($urandom_range(2), blk);
      ack_phase($urandom_range(10), 1'b0);
      done_phase($urandom_range(8), $urandom_range(4), $urandom());
    end

`ifdef HASH_REQ_TIMEOUT_EN
    // core never acks: err pulses once after TMO cycles in START
    begin
      int c = 0;
      rand_words(blk);
      send_block(0, blk);
      while (c <= 40) begin
        tick();
        c++;
        if (err) break;
      end
      check("timeout_cycle", 32'(c), 32'(TMO));
      check("timeout_start", 32'(start), 32'(START_IDLE));
      check("timeout_no_result", 32'(result_valid), 32'd0);
      tick();
      check("err_one_cycle", 32'(err), 32'd0);
      check("timeout_fill", 32'(req_ready), 32'd1);
      check("timeout_no_result2", 32'(result_valid), 32'd0);
      exp_q.delete();
    end
`endif

    repeat (2) tick();
    check("words_drained", 32'(exp_q.size()), 32'd0);
    check("hashes_drained", 32'(exp_hash_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
